debounce_multi: RTL

Parametrised multi-channel switch/button debouncer, the next generation of the single-channel explicit-FSMD debouncer.
- Per channel: 2-flop synchroniser, optional input inversion, 4-state FSM with stability counter.
- Outputs are a registered debounced level plus separate registered rise/fall one-cycle ticks.
- A shared clock-enable prescales the stability timing.
- Sits between board pushbuttons/slide switches and user logic (counters, UART test harness, LED demos).

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_chan.sv | 92 +++++++++
 rtl/debounce_multi.sv | 65 ++++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// debounce_pkg : shared state encoding and width constants for debounce_multi
// Revision 1.0
// ============================================================================
package debounce_pkg;

    localparam int STATE_W     = 2;
    localparam int SYNC_STAGES = 2;
    localparam int MAX_NCH     = 32;

    typedef enum logic [STATE_W-1:0] {
        ZERO  = 2'b00,
        WAIT0 = 2'b01,
        ONE   = 2'b10,
        WAIT1 = 2'b11
    } db_state_t;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// debounce_chan : one debounce channel (FSM, stability counter, level, ticks)
// Revision 1.0
// ============================================================================
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int N = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic s,
    output logic level,
    output logic rise_tick,
    output logic fall_tick,
    output logic tick_next
);

    db_state_t      state;
    logic [N-1:0]   cnt;
    logic [N-1:0]   cnt_dec;
    logic           done;
    logic           rise_next;
    logic           fall_next;

    // Saturating decrement: a zero count can never wrap back to the top.
    assign cnt_dec   = (cnt == '0) ? '0 : cnt - 1'b1;
    assign done      = ce && (cnt_dec == '0);
    assign rise_next = (state == WAIT1) && s && done;
    assign fall_next = (state == WAIT0) && !s && done;
    // Exposed so the top can register any_tick in the same cycle as the ticks.
    assign tick_next = rise_next | fall_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ZERO;
            cnt       <= '0;
            level     <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= rise_next;
            fall_tick <= fall_next;
            case (state)
                ZERO: begin
                    level <= 1'b0;
                    if (s) begin
                        state <= WAIT1;
                        cnt   <= '1;
                    end
                end
                WAIT1: begin
                    if (!s) begin
                        state <= ZERO;
                    end else if (ce) begin
                        cnt <= cnt_dec;
                        if (cnt_dec == '0) begin
                            state <= ONE;
                            level <= 1'b1;
                        end
                    end
                end
                ONE: begin
                    level <= 1'b1;
                    if (!s) begin
                        state <= WAIT0;
                        cnt   <= '1;
                    end
                end
                WAIT0: begin
                    if (s) begin
                        state <= ONE;
                    end else if (ce) begin
                        cnt <= cnt_dec;
                        if (cnt_dec == '0) begin
                            state <= ZERO;
                            level <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ZERO;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// debounce_multi : NCH-channel synchronising debouncer with shared prescaler
// Revision 1.0
// ============================================================================
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             N        = 21,
    parameter logic [NCH-1:0] INV_MASK = {NCH{1'b0}}
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce,
    input  logic [NCH-1:0] sw,
    output logic [NCH-1:0] db_level,
    output logic [NCH-1:0] rise_tick,
    output logic [NCH-1:0] fall_tick,
    output logic           any_tick
);

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] s;
    logic [NCH-1:0] tick_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    // Inversion follows the synchroniser, so inverted channels read 1 right after reset.
    assign s = sync2 ^ INV_MASK;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        debounce_chan #(
            .N (N)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .s         (s[i]),
            .level     (db_level[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i]),
            .tick_next (tick_next[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_tick <= 1'b0;
        end else begin
            any_tick <= |tick_next;
        end
    end

endmodule : debounce_multi
`default_nettype wire
